// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared constants and fetch-entry type for the instruction fetch stage
package if_pkg;

  localparam int PC_INC     = 4;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  localparam logic [DEF_ADDR_W-1:0] DEFAULT_RESET_PC = '0;

  // One prefetched instruction together with its PC and fall-through PC
  typedef struct packed {
    logic [DEF_ADDR_W-1:0] pc;
    logic [DEF_ADDR_W-1:0] pc_next;
    logic [DEF_DATA_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch queue with synchronous flush and push-while-full-on-pop
module fetch_fifo
  import if_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  entry_t                   wr_data,
  output entry_t                   head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  assign head = mem[rd_ptr];

  // Entry storage; flush wins over a same-cycle push
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy tracking; DEPTH is a power of 2 so pointers wrap naturally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: rtl/instr_fetch_q.sv
// rtl/instr_fetch_q.sv - fetch stage with prefetch queue; IF_PERF_CNT_EN adds event counters
module instr_fetch_q
  import if_pkg::*;
#(
  parameter int                ADDR_W     = DEF_ADDR_W,
  parameter int                DATA_W     = DEF_DATA_W,
  parameter int                IMEM_DEPTH = 64,
  parameter int                FQ_DEPTH   = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [ADDR_W-1:0]             pc_branch,
  input  logic                          pc_source,
  output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
  input  logic [DATA_W-1:0]             imem_data,
  input  logic                          id_ready,
  output logic                          if_valid,
  output logic [DATA_W-1:0]             instruction,
  output logic [ADDR_W-1:0]             pc_out,
  output logic [ADDR_W-1:0]             pc_next
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]                   fetch_cnt,
  output logic [31:0]                   redirect_cnt,
  output logic [31:0]                   stall_cnt
`endif
);

  localparam int IA_W  = $clog2(IMEM_DEPTH);
  localparam int CNT_W = $clog2(FQ_DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_next;
    logic [DATA_W-1:0] instr;
  } entry_t;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] redirect_pc;
  logic [CNT_W-1:0]  count;
  logic              full;
  logic              push;
  logic              pop;
  entry_t            wr_entry;
  entry_t            head;

  assign pc_inc      = pc + ADDR_W'(PC_INC);
  assign redirect_pc = pc_branch & ~ADDR_W'(3);
  assign imem_addr   = pc[IA_W+1:2];

  assign full     = (count == CNT_W'(FQ_DEPTH));
  assign if_valid = (count != '0);
  assign pop      = if_valid & id_ready & ~pc_source;
  assign push     = ~pc_source & (~full | pop);

  assign wr_entry = '{pc: pc, pc_next: pc_inc, instr: imem_data};

  assign instruction = if_valid ? head.instr   : '0;
  assign pc_out      = if_valid ? head.pc      : '0;
  assign pc_next     = if_valid ? head.pc_next : '0;

  fetch_fifo #(
    .DEPTH   (FQ_DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (pc_source),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_entry),
    .head    (head),
    .count   (count)
  );

  // PC: reload on redirect, advance only when the fetched word was captured
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= RESET_PC;
    end else if (pc_source) begin
      pc <= redirect_pc;
    end else if (push) begin
      pc <= pc_inc;
    end
  end

`ifdef IF_PERF_CNT_EN
  // Event counters: delivered instructions, redirect cycles, decode-stall cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_cnt    <= '0;
      redirect_cnt <= '0;
      stall_cnt    <= '0;
    end else begin
      if (pop)                   fetch_cnt    <= fetch_cnt + 32'd1;
      if (pc_source)             redirect_cnt <= redirect_cnt + 32'd1;
      if (if_valid && !id_ready) stall_cnt    <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_q.sv
// tb/tb_instr_fetch_q.sv - self-checking bench for instr_fetch_q
module tb_instr_fetch_q;

  logic        clk;
  logic        reset;
  logic [31:0] pc_branch;
  logic        pc_source;
  logic [5:0]  imem_addr;
  logic [31:0] imem_data;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] instruction;
  logic [31:0] pc_out;
  logic [31:0] pc_next;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] redirect_cnt;
  logic [31:0] stall_cnt;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  instr_fetch_q dut (
    .clk         (clk),
    .reset       (reset),
    .pc_branch   (pc_branch),
    .pc_source   (pc_source),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .id_ready    (id_ready),
    .if_valid    (if_valid),
    .instruction (instruction),
    .pc_out      (pc_out),
    .pc_next     (pc_next)
`ifdef IF_PERF_CNT_EN
    ,
    .fetch_cnt    (fetch_cnt),
    .redirect_cnt (redirect_cnt),
    .stall_cnt    (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // imem word k holds 0x1000 + k
  assign imem_data = 32'h1000 + 32'(imem_addr);

  function automatic exp_t mk(input int k);
    exp_t e;
    e.pc    = 32'(4 * k);
    e.instr = 32'h1000 + 32'(k % 64);
    return e;
  endfunction

  task automatic apply_reset();
    reset     = 1'b0;
    pc_source = 1'b0;
    pc_branch = '0;
    id_ready  = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    pc_source = 1'b0;
    pc_branch = '0;
    id_ready  = 1'b1;
    @(negedge clk);
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", if_valid); end
    checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", instruction); end
    checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc_out got %h exp 0", pc_out); end
    checks++; if (pc_next !== 32'h0) begin errors++; $display("FAIL reset_pc_next got %h exp 0", pc_next); end
    checks++; if (imem_addr !== 6'd0) begin errors++; $display("FAIL reset_imem_addr got %h exp 0", imem_addr); end
`ifdef IF_PERF_CNT_EN
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_stall_cnt got %0d exp 0", stall_cnt); end
`endif
  endtask

  task automatic test_stream();
    exp_t e;
    apply_reset();
    for (int k = 0; k < 16; k++) sb.push_back(mk(k));
    id_ready = 1'b1;
    reset    = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL stream_valid cyc %0d got %b exp 1", i, if_valid); end
      if (if_valid && sb.size() > 0) begin
        e = sb.pop_front();
        checks++; if (pc_out !== e.pc) begin errors++; $display("FAIL stream_pc got %h exp %h", pc_out, e.pc); end
        checks++; if (instruction !== e.instr) begin errors++; $display("FAIL stream_instr got %h exp %h", instruction, e.instr); end
        checks++; if (pc_next !== e.pc + 32'd4) begin errors++; $display("FAIL stream_pc_next got %h exp %h", pc_next, e.pc + 32'd4); end
      end
    end
  endtask

  task automatic test_stall_full();
    exp_t e;
    apply_reset();
    reset = 1'b1;
    repeat (10) @(negedge clk);
    checks++; if (imem_addr !== 6'd4) begin errors++; $display("FAIL stall_pc_hold got %h exp 04", imem_addr); end
    checks++; if (if_valid !== 1'b1 || pc_out !== 32'h0) begin errors++; $display("FAIL stall_head got %b/%h exp 1/0", if_valid, pc_out); end
`ifdef IF_PERF_CNT_EN
    checks++; if (stall_cnt !== 32'd9) begin errors++; $display("FAIL stall_cnt got %0d exp 9", stall_cnt); end
`endif
    for (int k = 0; k < 10; k++) sb.push_back(mk(k));
    id_ready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      e = sb.pop_front();
      checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL full_valid cyc %0d got %b exp 1", j, if_valid); end
      checks++; if (pc_out !== e.pc || instruction !== e.instr) begin errors++; $display("FAIL full_head got %h/%h exp %h/%h", pc_out, instruction, e.pc, e.instr); end
      checks++; if (imem_addr !== 6'(4 + j)) begin errors++; $display("FAIL full_push_pop_pc got %h exp %h", imem_addr, 6'(4 + j)); end
      @(negedge clk);
    end
  endtask

  task automatic test_redirect();
    exp_t e;
    apply_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (imem_addr !== 6'd3) begin errors++; $display("FAIL redir_pre_pc got %h exp 03", imem_addr); end
    pc_source = 1'b1;
    pc_branch = 32'h22;
    id_ready  = 1'b1;
    @(negedge clk);
    pc_source = 1'b0;
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL redir_n1_valid got %b exp 0", if_valid); end
    checks++; if (imem_addr !== 6'd8) begin errors++; $display("FAIL redir_n1_addr got %h exp 08", imem_addr); end
    for (int k = 8; k < 14; k++) sb.push_back(mk(k));
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      e = sb.pop_front();
      checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL redir_valid cyc %0d got %b exp 1", j, if_valid); end
      checks++; if (pc_out !== e.pc || instruction !== e.instr) begin errors++; $display("FAIL redir_head got %h/%h exp %h/%h", pc_out, instruction, e.pc, e.instr); end
      checks++; if (pc_next !== e.pc + 32'd4) begin errors++; $display("FAIL redir_pc_next got %h exp %h", pc_next, e.pc + 32'd4); end
    end
`ifdef IF_PERF_CNT_EN
    checks++; if (redirect_cnt !== 32'd1) begin errors++; $display("FAIL redirect_cnt got %0d exp 1", redirect_cnt); end
`endif
  endtask

  task automatic test_held_redirect();
    apply_reset();
    reset    = 1'b1;
    id_ready = 1'b1;
    @(negedge clk);
    pc_source = 1'b1;
    pc_branch = 32'h40;
    @(negedge clk);
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL held_valid_a got %b exp 0", if_valid); end
    pc_branch = 32'h80;
    @(negedge clk);
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL held_valid_b got %b exp 0", if_valid); end
    pc_branch = 32'h104;
    @(negedge clk);
    pc_source = 1'b0;
    checks++; if (if_valid !== 1'b0 || imem_addr !== 6'd1) begin errors++; $display("FAIL held_reload got %b/%h exp 0/01", if_valid, imem_addr); end
    @(negedge clk);
    checks++; if (pc_out !== 32'h104 || instruction !== 32'h1001) begin errors++; $display("FAIL held_target got %h/%h exp 00000104/00001001", pc_out, instruction); end
  endtask

  task automatic test_async_reset();
    exp_t e;
    apply_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL areset_pre_valid got %b exp 1", if_valid); end
    #2 reset = 1'b0;
    #1;
    checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %b exp 0", if_valid); end
    checks++; if (pc_out !== 32'h0 || instruction !== 32'h0) begin errors++; $display("FAIL areset_outs got %h/%h exp 0/0", pc_out, instruction); end
    checks++; if (imem_addr !== 6'd0) begin errors++; $display("FAIL areset_pc got %h exp 0", imem_addr); end
    @(negedge clk);
    reset    = 1'b1;
    id_ready = 1'b1;
    for (int k = 0; k < 4; k++) sb.push_back(mk(k));
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      e = sb.pop_front();
      checks++; if (if_valid !== 1'b1 || pc_out !== e.pc || instruction !== e.instr) begin errors++; $display("FAIL areset_restart got %b/%h/%h exp 1/%h/%h", if_valid, pc_out, instruction, e.pc, e.instr); end
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    reset = 1'b1;
    @(negedge clk);
    pc_source = 1'b1;
    pc_branch = 32'hFFFF_FFFF;
    @(negedge clk);
    pc_source = 1'b0;
    checks++; if (imem_addr !== 6'd63) begin errors++; $display("FAIL wrap_addr_top got %h exp 3f", imem_addr); end
    @(negedge clk);
    checks++; if (pc_out !== 32'hFFFF_FFFC || instruction !== 32'h103F) begin errors++; $display("FAIL wrap_head got %h/%h exp fffffffc/0000103f", pc_out, instruction); end
    checks++; if (pc_next !== 32'h0) begin errors++; $display("FAIL wrap_pc_next got %h exp 0", pc_next); end
    checks++; if (imem_addr !== 6'd0) begin errors++; $display("FAIL wrap_addr_zero got %h exp 0", imem_addr); end
    id_ready = 1'b1;
    @(negedge clk);
    checks++; if (pc_out !== 32'h0 || instruction !== 32'h1000 || pc_next !== 32'h4) begin errors++; $display("FAIL wrap_next got %h/%h/%h exp 0/1000/4", pc_out, instruction, pc_next); end
  endtask

  task automatic test_random_stall();
    exp_t e;
    int   pops;
    pops = 0;
    apply_reset();
    for (int k = 0; k < 100; k++) sb.push_back(mk(k));
    reset = 1'b1;
    for (int i = 0; i < 100; i++) begin
      id_ready = 1'($urandom_range(0, 1));
      if (if_valid && id_ready && sb.size() > 0) begin
        e = sb.pop_front();
        pops++;
        checks++; if (pc_out !== e.pc || instruction !== e.instr) begin errors++; $display("FAIL rand_head got %h/%h exp %h/%h", pc_out, instruction, e.pc, e.instr); end
      end
      @(negedge clk);
    end
    checks++; if (pops < 20) begin errors++; $display("FAIL rand_throughput got %0d exp >=20", pops); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall_full();
    test_redirect();
    test_held_redirect();
    test_async_reset();
    test_wrap();
    test_random_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
